// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  // Width of a RISC-V register index (x0..x31)
  localparam int REG_IDX_W = 5;

  // Width of the drain countdown; DRAIN_CYCLES is limited to 1..15
  localparam int DRAIN_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_DRAIN      = 2'd1,
    ST_HALT_DRAIN = 2'd2,
    ST_HALTED     = 2'd3
  } hazard_state_e;

endpackage : pipeline_hazard_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: the instruction in ID reads a
// register that a load currently in EX has not yet produced.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 load_use
);

  logic rs1Hit;
  logic rs2Hit;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard
  always_comb begin
    rs1Hit   = id_uses_rs1 && (ex_rd == id_rs1);
    rs2Hit   = id_uses_rs2 && (ex_rd == id_rs2);
    load_use = ex_mem_read && (ex_rd != '0) && (rs1Hit || rs2Hit);
  end

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage RISC-V core. Produces the PC and
// IF/ID enables and the IF/ID, ID/EX flushes for load-use stalls, taken
// branches, FENCE/ECALL drains and EBREAK halt, and counts stalled cycles.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_ebreak,
  input  logic                 id_fence,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_pc_src,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_count
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX    = {CNT_W{1'b1}};

  hazard_state_e           state_q, state_d;
  logic [DRAIN_CNT_W-1:0]  drainCnt_q, drainCnt_d;
  logic [CNT_W-1:0]        stallCount_q;
  logic                    loadUse;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (loadUse)
  );

  // Next-state and pipeline-control decode; stall outputs freeze PC and IF/ID
  // and inject a bubble into ID/EX. Reset overrides everything.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;

    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
      drainCnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ex_pc_src) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (loadUse) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (id_ebreak) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            drainCnt_d = DRAIN_LOAD;
            state_d    = ST_HALT_DRAIN;
          end else if (id_fence) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            drainCnt_d = DRAIN_LOAD;
            state_d    = ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          idex_flush = 1'b1;
          if (drainCnt_q != '0) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            drainCnt_d = drainCnt_q - 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_HALT_DRAIN: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (drainCnt_q <= DRAIN_CNT_W'(1)) begin
            drainCnt_d = '0;
            state_d    = ST_HALTED;
          end else begin
            drainCnt_d = drainCnt_q - 1'b1;
          end
        end

        ST_HALTED: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          halted     = 1'b1;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State, drain countdown and saturating stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      drainCnt_q   <= '0;
      stallCount_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      if (!pc_write && (stallCount_q != CNT_MAX)) begin
        stallCount_q <= stallCount_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stallCount_q;

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, id_ebreak, id_fence;
  logic       ex_mem_read, ex_pc_src;

  logic        pc_write, ifid_write, ifid_flush, idex_flush, halted;
  logic [31:0] stall_count;
  logic        pc_write4, ifid_write4, ifid_flush4, idex_flush4, halted4;
  logic [3:0]  stall_count4;

  int checks = 0;
  int errors = 0;

  // Model state: remaining stall cycles of an EBREAK/FENCE drain, a pending
  // release cycle after a FENCE, sticky halt and the stalled-cycle total.
  int          fenceLeft, ebreakLeft;
  bit          releaseM, haltedM;
  longint      stallM;
  bit          ePc, eIfid, eIfidF, eIdexF, eHalt;
  int          nF, nE;
  bit          nR, nH;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ebreak(id_ebreak), .id_fence(id_fence), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_pc_src(ex_pc_src), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_count(stall_count)
  );

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ebreak(id_ebreak), .id_fence(id_fence), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_pc_src(ex_pc_src), .pc_write(pc_write4),
    .ifid_write(ifid_write4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .halted(halted4), .stall_count(stall_count4)
  );

  function automatic bit modelLoadUse();
    bit hit1, hit2;
    hit1 = id_uses_rs1 && (ex_rd == id_rs1);
    hit2 = id_uses_rs2 && (ex_rd == id_rs2);
    return ex_mem_read && (ex_rd != 5'd0) && (hit1 || hit2);
  endfunction

  task automatic setExp(input bit p, input bit w, input bit f1, input bit f2, input bit h);
    ePc = p; eIfid = w; eIfidF = f1; eIdexF = f2; eHalt = h;
  endtask

  // Expected outputs for the current inputs plus the model's next state
  task automatic modelEval();
    nF = fenceLeft; nE = ebreakLeft; nR = releaseM; nH = haltedM;
    if (rst) begin
      setExp(0, 0, 1, 1, 0);
      nF = 0; nE = 0; nR = 0; nH = 0;
    end else if (haltedM) begin
      setExp(0, 0, 0, 1, 1);
    end else if (ebreakLeft > 0) begin
      setExp(0, 0, 0, 1, 0);
      nE = ebreakLeft - 1;
      if (nE == 0) nH = 1;
    end else if (fenceLeft > 0) begin
      setExp(0, 0, 0, 1, 0);
      nF = fenceLeft - 1;
      if (nF == 0) nR = 1;
    end else if (releaseM) begin
      setExp(1, 1, 0, 1, 0);
      nR = 0;
    end else if (ex_pc_src) begin
      setExp(1, 1, 1, 1, 0);
    end else if (modelLoadUse()) begin
      setExp(0, 0, 0, 1, 0);
    end else if (id_ebreak) begin
      setExp(0, 0, 0, 1, 0);
      nE = DRAIN - 1;
      if (nE == 0) nH = 1;
    end else if (id_fence) begin
      setExp(0, 0, 0, 1, 0);
      nF = DRAIN - 1;
      if (nF == 0) nR = 1;
    end else begin
      setExp(1, 1, 0, 0, 0);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit ps, input bit mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                               input bit u2, input bit eb, input bit fe);
    rst = r; ex_pc_src = ps; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_ebreak = eb; id_fence = fe;
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output mid-cycle, then advance the model across the edge
  task automatic checkOutput(input string tag);
    longint exp4;
    @(negedge clk);
    modelEval();
    exp4 = (stallM > 15) ? 15 : stallM;
    checkBit({tag, ".pc_write"},   pc_write,   ePc);
    checkBit({tag, ".ifid_write"}, ifid_write, eIfid);
    checkBit({tag, ".ifid_flush"}, ifid_flush, eIfidF);
    checkBit({tag, ".idex_flush"}, idex_flush, eIdexF);
    checkBit({tag, ".halted"},     halted,     eHalt);
    checks++;
    assert (stall_count === 32'(stallM)) else begin
      errors++;
      $error("[TB] FAIL %s.stall_count: observed=%0d expected=%0d", tag, stall_count, stallM);
    end
    checks++;
    assert (stall_count4 === 4'(exp4)) else begin
      errors++;
      $error("[TB] FAIL %s.stall_count4: observed=%0d expected=%0d", tag, stall_count4, exp4);
    end
    @(posedge clk);
    fenceLeft = nF; ebreakLeft = nE; releaseM = nR; haltedM = nH;
    if (rst) stallM = 0;
    else if (!ePc) stallM++;
    #1;
  endtask

  initial begin
    fenceLeft = 0; ebreakLeft = 0; releaseM = 0; haltedM = 0; stallM = 0;
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    #1;
    checkOutput("reset0");
    checkOutput("reset1");
    applyIdle();
    checkOutput("idle0");
    checkOutput("idle1");

    // Load-use on rs1
    applyStimulus(0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0);
    checkOutput("loaduse");
    applyIdle();
    checkOutput("after_lu");
    checkBit("lu_count_is_1", stall_count == 32'd1, 1'b1);

    // x0 destination and unused rs2 never stall
    applyStimulus(0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);
    checkOutput("x0_no_stall");
    applyStimulus(0, 0, 1, 5'd7, 5'd1, 1, 5'd7, 0, 0, 0);
    checkOutput("unused_rs2");

    // Taken branch outranks load-use and EBREAK
    applyStimulus(0, 1, 1, 5'd9, 5'd9, 1, 5'd0, 0, 1, 0);
    checkOutput("branch_prio");
    applyIdle();
    checkOutput("after_branch");

    // FENCE drain: three stall cycles, then release
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1);
    checkOutput("fence0");
    applyIdle();
    for (int i = 0; i < 4; i++) checkOutput("fence_drain");

    // EBREAK with FENCE: EBREAK wins, halt held for 100+ cycles
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1);
    checkOutput("ebreak0");
    applyStimulus(0, 1, 1, 5'd3, 5'd3, 1, 5'd3, 1, 0, 1);
    for (int i = 0; i < 104; i++) checkOutput("halt_hold");
    checkBit("halted_sticky", halted, 1'b1);
    checkBit("sat_count4", stall_count4 == 4'd15, 1'b1);

    // Reset while halted, then normal fetch resumes
    applyStimulus(1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    checkOutput("halt_reset");
    applyIdle();
    checkOutput("resume0");
    checkOutput("resume1");

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 1) == 0),
                    5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 14) == 0));
      checkOutput("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RISC-V pipeline. Generates PC write-enable, IF/ID write-enable and the IF/ID and ID/EX flush controls.
- Handles four cases: load-use stalls, taken branch/jump flushes, FENCE/ECALL drains and EBREAK halt.
- Sits beside the ID stage. Consumes decoded ID-stage control flags, EX-stage register and branch info.
- Drives pipeline-register enables combinationally in the same cycle.

Parameters:
- DRAIN_CYCLES, 3, cycles to wait for older instructions to retire (EX, MEM, WB); legal range 1..15.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 field of instruction in ID
- id_rs2  in  5  rs2 field of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_ebreak  in  1  ID instruction is EBREAK (decoder Ebreak flag)
- id_fence  in  1  ID instruction is FENCE/ECALL (decoder UnconditionalJump flag)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of instruction in EX
- ex_pc_src  in  1  branch/jump in EX resolved taken
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID register replaced by NOP
- idex_flush  out  1  ID/EX control bits zeroed (bubble)
- halted  out  1  core halted by EBREAK; sticky
- stall_count  out  CNT_W  number of cycles with pc_write=0

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high.
- Reset outputs: while rst=1, force pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1 and halted=0.
- Reset state: on the edge, state=RUN, drain counter=0, stall_count=0.
- Output timing: outputs are combinational from state, counter and inputs (zero latency). State, counter and stall_count are registered.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- RUN, evaluated in strict priority order:
  1. ex_pc_src: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; stay RUN. The branch outranks everything because the ID instruction is on the wrong path.
  2. load_use: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0; stay RUN for one bubble.
  3. id_ebreak: stall outputs (pc_write=0, ifid_write=0, idex_flush=1); counter<=DRAIN_CYCLES-1; go to HALT_DRAIN.
  4. id_fence: stall outputs; counter<=DRAIN_CYCLES-1; go to DRAIN.
  5. Otherwise: pc_write=1, ifid_write=1, both flushes 0.
- DRAIN (counter!=0): stall outputs; counter decrements each cycle.
- DRAIN (counter==0): pc_write=1, ifid_write=1, idex_flush=1. The FENCE is discarded and the next instruction is loaded into ID. Next state is RUN.
- HALT_DRAIN: stall outputs; counter decrements; at counter==0 go to HALTED.
- HALTED: pc_write=0, ifid_write=0, idex_flush=1, halted=1. Stays HALTED until rst.
- Inputs ignored in DRAIN, HALT_DRAIN and HALTED: ex_pc_src, load_use, id_ebreak and id_fence. EX holds bubbles in these states, so none can legally assert.
- id_ebreak and id_fence both asserted: ebreak wins.
- DRAIN_CYCLES=1: a single stall cycle with counter already 0, so the exit behaviour applies on the first cycle.
- stall_count: increments every cycle pc_write=0 and rst=0, including HALTED. Saturates at all-ones (no wrap).
- Reset mid-drain or while halted: returns to RUN immediately, with reset outputs during the rst cycle.

Decomposition:
- Shared defines file (defines.v): state encodings `PCTL_RUN`, `PCTL_DRAIN`, `PCTL_HALT_DRAIN`, `PCTL_HALTED` (2 bits), plus the register-index width macro.
- One natural sub-module: load_use_detect. It is purely combinational and computes load_use from the id_* and ex_* ports. Instantiate it once.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_count=1; next cycle normal.
- x0 and unused operand: ex_rd=0=id_rs1 with load in EX -> no stall. Same with ex_rd=7=id_rs2 but id_uses_rs2=0 -> no stall.
- Branch priority: ex_pc_src=1 together with load_use=1 and id_ebreak=1 -> ifid_flush=1, idex_flush=1, pc_write=1; state stays RUN; halted stays 0.
- Fence, DRAIN_CYCLES=3: id_fence pulse -> pc_write=0 for exactly 3 cycles, then one cycle with pc_write=1, ifid_write=1, idex_flush=1; stall_count=3.
- EBREAK: id_ebreak=1 -> halted=1 from the 4th cycle onward and held for 100 cycles. stall_count keeps incrementing. rst mid-HALTED -> halted=0 the following cycle and normal fetch resumes.
- Saturation: CNT_W=4, hold HALTED for 20 cycles -> stall_count=15 and stays there.
